rvx_sreq_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one single-beat register-request channel (the upstream side of the AXI single-transfer bridge) between NUM_REQ requesters. It accepts one request at a time, latches it, and issues it downstream. It then returns the response only to the requester that owns it. At most one transaction is outstanding. Fairness comes from a rotating priority pointer.

---
 rtl/rvx_sreq_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_rvx_sreq_rr_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvx_sreq_rr_arbiter.sv
// Round-robin arbiter sharing one single-beat register-request channel among NUM_REQ requesters.
// One transaction in flight; the response is routed back only to the requester that owns it.
module rvx_sreq_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int BW_ADDR  = 32,
  parameter int BW_DATA  = 32,
  parameter int BW_GRANT = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rstnn,
  input  logic [NUM_REQ-1:0]         s_req_valid,
  output logic [NUM_REQ-1:0]         s_req_ready,
  input  logic [NUM_REQ-1:0]         s_req_write,
  input  logic [NUM_REQ*BW_ADDR-1:0] s_req_addr,
  input  logic [NUM_REQ*BW_DATA-1:0] s_req_wdata,
  output logic [NUM_REQ-1:0]         s_rsp_valid,
  input  logic [NUM_REQ-1:0]         s_rsp_ready,
  output logic [BW_DATA-1:0]         s_rsp_rdata,
  output logic                       s_rsp_error,
  output logic                       m_req_valid,
  input  logic                       m_req_ready,
  output logic                       m_req_write,
  output logic [BW_ADDR-1:0]         m_req_addr,
  output logic [BW_DATA-1:0]         m_req_wdata,
  input  logic                       m_rsp_valid,
  output logic                       m_rsp_ready,
  input  logic [BW_DATA-1:0]         m_rsp_rdata,
  input  logic                       m_rsp_error,
  output logic [1:0]                 dbg_state,
  output logic [BW_GRANT-1:0]        dbg_grant,
  output logic [BW_GRANT-1:0]        dbg_ptr
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and a raised valid holds its payload until accepted.

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]          state;
  logic [BW_GRANT-1:0] grant;
  logic [BW_GRANT-1:0] ptr;
  logic                req_write_q;
  logic [BW_ADDR-1:0]  req_addr_q;
  logic [BW_DATA-1:0]  req_wdata_q;
  logic [BW_DATA-1:0]  rsp_rdata_q;
  logic                rsp_error_q;

  logic                any;
  logic [BW_GRANT-1:0] winner;
  logic                found;
  logic [BW_GRANT:0]   idx;
  logic [BW_GRANT-1:0] cand;

  assign any = |s_req_valid;

  // Scan ptr, ptr+1, ... modulo NUM_REQ; the extra index bit keeps the wrap exact for
  // non-power-of-two NUM_REQ so the winner never exceeds NUM_REQ-1.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (BW_GRANT+1)'(k);
      if (idx >= (BW_GRANT+1)'(NUM_REQ)) idx = idx - (BW_GRANT+1)'(NUM_REQ);
      cand = idx[BW_GRANT-1:0];
      if (!found && s_req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign s_req_ready = (state == IDLE && any) ? (NUM_REQ'(1) << winner) : '0;
  assign s_rsp_valid = (state == RESP) ? (NUM_REQ'(1) << grant) : '0;
  assign s_rsp_rdata = rsp_rdata_q;
  assign s_rsp_error = rsp_error_q;
  assign m_req_valid = (state == ISSUE);
  assign m_req_write = req_write_q;
  assign m_req_addr  = req_addr_q;
  assign m_req_wdata = req_wdata_q;
  assign m_rsp_ready = (state == WAIT);

  assign dbg_state = state;
  assign dbg_grant = grant;
  assign dbg_ptr   = ptr;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state       <= IDLE;
      grant       <= '0;
      ptr         <= '0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            grant       <= winner;
            req_write_q <= s_req_write[winner];
            req_addr_q  <= s_req_addr[winner*BW_ADDR +: BW_ADDR];
            req_wdata_q <= s_req_wdata[winner*BW_DATA +: BW_DATA];
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (m_rsp_valid) begin
            rsp_rdata_q <= m_rsp_rdata;
            rsp_error_q <= m_rsp_error;
            state       <= RESP;
          end
        end
        RESP: begin
          if (s_rsp_ready[grant]) begin
            ptr   <= (grant == BW_GRANT'(NUM_REQ-1)) ? '0 : grant + BW_GRANT'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rvx_sreq_rr_arbiter.sv
// Bench for rvx_sreq_rr_arbiter: cycle-stepped requester/downstream drivers with a
// response scoreboard keyed on {requester, error, rdata}.
module tb_rvx_sreq_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int GW = 2;
  localparam int W  = GW + 1 + DW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic            clk = 1'b0;
  logic            rstnn;
  logic [N-1:0]    s_req_valid;
  logic [N-1:0]    s_req_ready;
  logic [N-1:0]    s_req_write;
  logic [N*AW-1:0] s_req_addr;
  logic [N*DW-1:0] s_req_wdata;
  logic [N-1:0]    s_rsp_valid;
  logic [N-1:0]    s_rsp_ready;
  logic [DW-1:0]   s_rsp_rdata;
  logic            s_rsp_error;
  logic            m_req_valid;
  logic            m_req_ready;
  logic            m_req_write;
  logic [AW-1:0]   m_req_addr;
  logic [DW-1:0]   m_req_wdata;
  logic            m_rsp_valid;
  logic            m_rsp_ready;
  logic [DW-1:0]   m_rsp_rdata;
  logic            m_rsp_error;
  logic [1:0]      dbg_state;
  logic [GW-1:0]   dbg_grant;
  logic [GW-1:0]   dbg_ptr;

  logic [AW-1:0]   req_addr  [N];
  logic [DW-1:0]   req_wdata [N];

  logic [W-1:0]    exp_q[$];
  int              n_tests = 0;
  int              n_fail  = 0;

  rvx_sreq_rr_arbiter #(.NUM_REQ(N), .BW_ADDR(AW), .BW_DATA(DW)) dut (
    .clk(clk), .rstnn(rstnn),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_write(s_req_write),
    .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata),
    .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready),
    .s_rsp_rdata(s_rsp_rdata), .s_rsp_error(s_rsp_error),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_write(m_req_write),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
    .m_rsp_rdata(m_rsp_rdata), .m_rsp_error(m_rsp_error),
    .dbg_state(dbg_state), .dbg_grant(dbg_grant), .dbg_ptr(dbg_ptr)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  always_comb begin
    s_req_addr  = '0;
    s_req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      s_req_addr[i*AW +: AW]  = req_addr[i];
      s_req_wdata[i*DW +: DW] = req_wdata[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v == (N'(1) << i)) r = i;
    return r;
  endfunction

  task automatic idle_inputs();
    s_req_valid = '0;
    s_req_write = '0;
    s_rsp_ready = '0;
    m_req_ready = 1'b0;
    m_rsp_valid = 1'b0;
    m_rsp_rdata = '0;
    m_rsp_error = 1'b0;
  endtask

  // Drives one full transaction that the arbiter is expected to grant to requester r.
  task automatic do_txn(input int r, input logic [DW-1:0] rdata, input logic err,
                        input int req_stall, input int rsp_stall, input bit spurious,
                        input bit drop_req);
    int got_idx;
    logic [DW-1:0] held_rdata;
    logic [W-1:0] exp_v;
    #1;
    check("accept_ready", 64'(s_req_ready), 64'(N'(1) << r));
    exp_q.push_back({GW'(r), err, rdata});
    tick();
    if (drop_req) s_req_valid[r] = 1'b0;
    for (int i = 0; i < req_stall; i++) begin
      m_rsp_valid = spurious && (i == 0);
      m_rsp_rdata = 32'hBAD0_BAD0;
      #1;
      check("issue_valid", 64'(m_req_valid), 64'd1);
      check("issue_addr", 64'(m_req_addr), 64'(req_addr[r]));
      check("issue_wdata", 64'(m_req_wdata), 64'(req_wdata[r]));
      check("issue_no_rsp_ready", 64'(m_rsp_ready), 64'd0);
      check("issue_no_req_ready", 64'(s_req_ready), 64'd0);
      tick();
      m_rsp_valid = 1'b0;
      m_rsp_rdata = '0;
    end
    m_req_ready = 1'b1;
    #1;
    check("issue_state", 64'(dbg_state), 64'(S_ISSUE));
    check("issue_valid", 64'(m_req_valid), 64'd1);
    check("issue_addr", 64'(m_req_addr), 64'(req_addr[r]));
    check("issue_write", 64'(m_req_write), 64'(s_req_write[r]));
    check("issue_wdata", 64'(m_req_wdata), 64'(req_wdata[r]));
    tick();
    m_req_ready = 1'b0;
    m_rsp_valid = 1'b1;
    m_rsp_rdata = rdata;
    m_rsp_error = err;
    #1;
    check("wait_rsp_ready", 64'(m_rsp_ready), 64'd1);
    check("wait_no_req_valid", 64'(m_req_valid), 64'd0);
    tick();
    m_rsp_valid = 1'b0;
    m_rsp_rdata = '0;
    m_rsp_error = 1'b0;
    #1;
    got_idx = onehot_idx(s_rsp_valid);
    check("rsp_valid", 64'(s_rsp_valid), 64'(N'(1) << r));
    if (exp_q.size() == 0) begin
      check("rsp_unexpected", 64'd1, 64'd0);
    end else begin
      exp_v = exp_q.pop_front();
      check("rsp_scoreboard", 64'({GW'(got_idx), s_rsp_error, s_rsp_rdata}), 64'(exp_v));
    end
    held_rdata = s_rsp_rdata;
    for (int i = 0; i < rsp_stall; i++) begin
      s_rsp_ready = ~(N'(1) << r);
      tick();
      check("rsp_hold_valid", 64'(s_rsp_valid), 64'(N'(1) << r));
      check("rsp_hold_rdata", 64'(s_rsp_rdata), 64'(held_rdata));
      check("rsp_hold_no_req_ready", 64'(s_req_ready), 64'd0);
    end
    s_rsp_ready = N'(1) << r;
    tick();
    s_rsp_ready = '0;
    #1;
    check("done_state", 64'(dbg_state), 64'(S_IDLE));
    check("done_ptr", 64'(dbg_ptr), 64'((r + 1) % N));
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < N; i++) begin
      req_addr[i]  = 32'h1000 + 32'(i * 16);
      req_wdata[i] = 32'hA5A5_0000 + 32'(i);
    end

    // reset state, with a request visible during reset
    rstnn = 1'b0;
    s_req_valid = 4'b0100;
    #12;
    check("rst_req_ready", 64'(s_req_ready), 64'b0100);
    check("rst_m_req_valid", 64'(m_req_valid), 64'd0);
    check("rst_m_rsp_ready", 64'(m_rsp_ready), 64'd0);
    check("rst_s_rsp_valid", 64'(s_rsp_valid), 64'd0);
    check("rst_rsp_fields", 64'({s_rsp_error, s_rsp_rdata}), 64'd0);
    check("rst_ptr_grant", 64'({dbg_ptr, dbg_grant, dbg_state}), 64'd0);
    check("rst_m_req_fields", 64'({m_req_write, m_req_addr}), 64'd0);
    s_req_valid = '0;
    @(negedge clk);
    rstnn = 1'b1;
    tick();

    // rotation: everyone valid, reads return the requester index
    for (int i = 0; i < N; i++) begin
      req_addr[i]  = $urandom;
      req_wdata[i] = $urandom;
    end
    s_req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) do_txn(k % N, DW'(k % N), 1'b0, $urandom_range(0, 2), 0, 1'b0, 1'b0);

    // single requester write
    s_req_valid    = 4'b0100;
    s_req_write    = 4'b0100;
    req_addr[2]    = 32'h100;
    req_wdata[2]   = 32'hDEAD_BEEF;
    do_txn(2, 32'h0, 1'b0, 0, 0, 1'b0, 1'b1);
    check("single_ptr", 64'(dbg_ptr), 64'd3);
    s_req_write = '0;

    // wrap and skip: ptr=3, requesters 1 and 3
    s_req_valid = 4'b1010;
    do_txn(3, 32'h33, 1'b0, 0, 0, 1'b0, 1'b1);
    do_txn(1, 32'h11, 1'b0, 0, 0, 1'b0, 1'b1);
    check("wrap_ptr", 64'(dbg_ptr), 64'd2);

    // backpressure on both sides, others keep requesting
    s_req_valid = 4'b1111;
    req_addr[2] = $urandom;
    do_txn(2, $urandom, 1'b0, 5, 3, 1'b0, 1'b1);
    s_req_valid = '0;

    // spurious response during ISSUE, then error response
    s_req_valid = 4'b0010;
    do_txn(1, 32'h0, 1'b1, 2, 0, 1'b1, 1'b1);

    // reset while waiting for the downstream response
    s_req_valid = 4'b0001;
    #1;
    tick();
    s_req_valid = '0;
    m_req_ready = 1'b1;
    tick();
    m_req_ready = 1'b0;
    #1;
    check("midrst_in_wait", 64'(dbg_state), 64'(S_WAIT));
    #1;
    rstnn = 1'b0;
    #1;
    check("midrst_m_rsp_ready", 64'(m_rsp_ready), 64'd0);
    check("midrst_m_req_valid", 64'(m_req_valid), 64'd0);
    check("midrst_s_rsp_valid", 64'(s_rsp_valid), 64'd0);
    check("midrst_ptr", 64'(dbg_ptr), 64'd0);
    check("midrst_m_req_addr", 64'(m_req_addr), 64'd0);
    @(negedge clk);
    rstnn = 1'b1;
    tick();
    s_req_valid = 4'b0001;
    req_addr[0] = 32'h40;
    do_txn(0, 32'hCAFE_F00D, 1'b0, 0, 0, 1'b0, 1'b1);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
